// File: rtl/regfile_wr_arbiter.sv
// Write-port owner for the 32x64 LEGv8 register file: runs the xi = i init pass
// after reset, then arbitrates the ALU (A) and load (B) write-backs round-robin.
module regfile_wr_arbiter #(
    parameter int N_REG = 32,
    parameter int W     = 64
) (
    input  logic         clk,
    input  logic         reset,
    output logic         init_busy,
    input  logic         a_req,
    input  logic [4:0]   a_addr,
    input  logic [W-1:0] a_data,
    output logic         a_gnt,
    input  logic         b_req,
    input  logic [4:0]   b_addr,
    input  logic [W-1:0] b_data,
    output logic         b_gnt,
    output logic         we3,
    output logic [4:0]   wa3,
    output logic [W-1:0] wd3
);

    typedef enum logic {INIT, RUN} state_t;

    localparam logic [4:0] XZR      = 5'(N_REG - 1);
    localparam logic [4:0] LAST_REG = 5'(N_REG - 2);

    state_t         state_reg, state_next;
    logic [4:0]     cnt_reg, cnt_next;
    logic           prio_reg, prio_next;
    logic           we3_reg, we3_next;
    logic [4:0]     wa3_reg, wa3_next;
    logic [W-1:0]   wd3_reg, wd3_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= INIT;
            cnt_reg   <= '0;
            prio_reg  <= 1'b0;
            we3_reg   <= 1'b0;
            wa3_reg   <= '0;
            wd3_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            prio_reg  <= prio_next;
            we3_reg   <= we3_next;
            wa3_reg   <= wa3_next;
            wd3_reg   <= wd3_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        prio_next  = prio_reg;
        we3_next   = 1'b0;
        wa3_next   = wa3_reg;
        wd3_next   = wd3_reg;
        a_gnt      = 1'b0;
        b_gnt      = 1'b0;

        case (state_reg)
            INIT: begin
                we3_next = 1'b1;
                wa3_next = cnt_reg;
                wd3_next = {{(W-5){1'b0}}, cnt_reg};
                cnt_next = cnt_reg + 5'd1;
                if (cnt_reg == LAST_REG)
                    state_next = RUN;
            end
            RUN: begin
                a_gnt = a_req & (~b_req | ~prio_reg);
                b_gnt = b_req & (~a_req |  prio_reg);
                // XZR writes are consumed but never reach the regfile; wa3/wd3 hold.
                if (a_gnt) begin
                    prio_next = 1'b1;
                    if (a_addr != XZR) begin
                        we3_next = 1'b1;
                        wa3_next = a_addr;
                        wd3_next = a_data;
                    end
                end else if (b_gnt) begin
                    prio_next = 1'b0;
                    if (b_addr != XZR) begin
                        we3_next = 1'b1;
                        wa3_next = b_addr;
                        wd3_next = b_data;
                    end
                end
            end
            default: state_next = INIT;
        endcase
    end

    assign init_busy = (state_reg == INIT);
    assign we3       = we3_reg;
    assign wa3       = wa3_reg;
    assign wd3       = wd3_reg;

endmodule
